// File: rtl/mfp_ahb_bot_regs_if.sv
// AHB-lite slave-side bus bundle for the RojoBot register block.
// HREADY is not carried: the slave is zero-wait and the interconnect ties it high.
interface mfp_ahb_bot_regs_if;
    logic [2:0]  HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (output HADDR, HTRANS, HWDATA, HWRITE, HSEL, input HRDATA);
    modport slave  (input HADDR, HTRANS, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_bot_regs.sv
// AHB-lite register slave bridging the MIPSfpga core to the RojoBot: motor control out,
// status snapshot on each bot update, sticky update/overrun flags with software acknowledge.
module mfp_ahb_bot_regs #(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] CTRL_RST = 8'h00
) (
    input  logic              HCLK,
    input  logic              HRESET,
    mfp_ahb_bot_regs_if.slave bus,
    input  logic [31:0]       IO_BotInfo,
    input  logic              IO_BotUpd,
    output logic [7:0]        IO_BotCtrl,
    output logic              IO_BotIrq
);

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_INFO = 3'd1;
    localparam logic [2:0] A_STAT = 3'd2;
    localparam logic [2:0] A_ACK  = 3'd3;
    localparam logic [2:0] A_CNT  = 3'd4;

    logic             we_d;
    logic [2:0]       addr_d;
    logic [7:0]       ctrl;
    logic [31:0]      info;
    logic             upd_flag;
    logic             overrun;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rd_mux;
    logic             addr_ok;
    logic             wr_ctrl;
    logic             ack;
    logic             unused_bits;

    assign addr_ok     = bus.HSEL & bus.HTRANS[1];
    assign wr_ctrl     = we_d & (addr_d == A_CTRL);
    assign ack         = we_d & (addr_d == A_ACK) & bus.HWDATA[0];
    assign unused_bits = ^{bus.HTRANS[0], bus.HWDATA[31:8]};

    // Data-phase writes are forwarded so a read right behind a write sees the new value;
    // bot updates in the same cycle are not, so INFO/STAT read their pre-update contents.
    always_comb begin
        rd_mux = 32'h0;
        case (bus.HADDR)
            A_CTRL: rd_mux = {24'h0, wr_ctrl ? bus.HWDATA[7:0] : ctrl};
            A_INFO: rd_mux = info;
            A_STAT: rd_mux = ack ? 32'h0 : {30'h0, overrun, upd_flag};
            A_CNT:  rd_mux = 32'(cnt);
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            we_d       <= 1'b0;
            addr_d     <= 3'd0;
            bus.HRDATA <= 32'h0;
        end else begin
            we_d <= addr_ok & bus.HWRITE;
            if (addr_ok)
                addr_d <= bus.HADDR;
            if (addr_ok & ~bus.HWRITE)
                bus.HRDATA <= rd_mux;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            ctrl <= CTRL_RST;
        else if (wr_ctrl)
            ctrl <= bus.HWDATA[7:0];
    end

    // An update coinciding with an ACK leaves the flag set but no overrun.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            info     <= 32'h0;
            upd_flag <= 1'b0;
            overrun  <= 1'b0;
            cnt      <= '0;
        end else if (IO_BotUpd) begin
            info     <= IO_BotInfo;
            upd_flag <= 1'b1;
            overrun  <= ack ? 1'b0 : (overrun | upd_flag);
            cnt      <= cnt + CNT_W'(1);
        end else if (ack) begin
            upd_flag <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign IO_BotCtrl = ctrl;
    assign IO_BotIrq  = upd_flag;

endmodule

// File: tb/tb_mfp_ahb_bot_regs.sv
// Scoreboard bench for mfp_ahb_bot_regs: directed scenarios then random bus/update traffic,
// checked against a register-level reference model applied in program order.
module tb_mfp_ahb_bot_regs;
    localparam int CNT_W = 4;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] IO_BotInfo = 32'h0;
    logic        IO_BotUpd = 1'b0;
    logic [7:0]  IO_BotCtrl;
    logic        IO_BotIrq;

    mfp_ahb_bot_regs_if bus ();

    mfp_ahb_bot_regs #(.CNT_W(CNT_W), .CTRL_RST(8'h00)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
        .IO_BotInfo(IO_BotInfo), .IO_BotUpd(IO_BotUpd),
        .IO_BotCtrl(IO_BotCtrl), .IO_BotIrq(IO_BotIrq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          rd;
        logic [31:0] rd_exp;
        logic [7:0]  ctrl;
        bit          irq;
    } scb_t;

    scb_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [7:0]  m_ctrl;
    logic [31:0] m_info;
    bit          m_flag, m_ovr;
    int          m_cnt;
    bit          pend_we;
    logic [2:0]  pend_a;
    logic [31:0] pend_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_ctrl};
            3'd1: return m_info;
            3'd2: return {30'h0, m_ovr, m_flag};
            3'd4: return 32'(m_cnt);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] wd);
        if (a == 3'd0) m_ctrl = wd[7:0];
        if (a == 3'd3 && wd[0]) begin m_flag = 0; m_ovr = 0; end
    endtask

    task automatic model_upd(input logic [31:0] info);
        m_info = info;
        if (m_flag) m_ovr = 1;
        m_flag = 1;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic model_reset();
        m_ctrl = 8'h00; m_info = 0; m_flag = 0; m_ovr = 0; m_cnt = 0;
        pend_we = 0; pend_a = 0; pend_wd = 0;
    endtask

    // One bus cycle: data phase of the previous transfer, address phase of this one, optional update.
    task automatic cyc(input bit sel, input bit wr, input logic [2:0] a,
                       input logic [31:0] wd, input bit upd, input logic [31:0] info);
        scb_t e;
        logic hs;
        @(negedge HCLK);
        bus.HWDATA = pend_we ? pend_wd : $urandom();
        if (pend_we) model_write(pend_a, pend_wd);
        if (sel) begin
            bus.HSEL   = 1'b1;
            bus.HTRANS = {1'b1, 1'($urandom_range(0, 1))};
            bus.HWRITE = wr;
            bus.HADDR  = a;
        end else begin
            hs = 1'($urandom_range(0, 1));
            bus.HSEL   = hs;
            bus.HTRANS = hs ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
            bus.HWRITE = 1'($urandom_range(0, 1));
            bus.HADDR  = 3'($urandom_range(0, 7));
        end
        e.rd     = sel && !wr;
        e.rd_exp = e.rd ? model_read(a) : 32'h0;
        pend_we  = sel && wr;
        pend_a   = a;
        pend_wd  = wd;
        IO_BotUpd  = upd;
        IO_BotInfo = upd ? info : $urandom();
        if (upd) model_upd(info);
        e.ctrl = m_ctrl;
        e.irq  = m_flag;
        q.push_back(e);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1, 0, a, 32'h0, 0, 32'h0);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1, 1, a, d, 0, 32'h0);
    endtask
    task automatic idle(input bit upd, input logic [31:0] info);
        cyc(0, 0, 3'd0, 32'h0, upd, info);
    endtask

    // Reset asserted mid-cycle, right after the address phase of a pending transfer.
    task automatic mid_reset();
        @(posedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        chk("rst_ctrl", {24'h0, IO_BotCtrl}, 32'h0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_irq", {31'h0, IO_BotIrq}, 32'h0);
        @(negedge HCLK);
        bus.HSEL = 0; bus.HTRANS = 0; IO_BotUpd = 0; bus.HWDATA = pend_wd;
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    // Monitor: pops one expectation per active cycle and compares DUT outputs.
    initial begin
        scb_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", {24'h0, IO_BotCtrl}, {24'h0, e.ctrl});
                chk("irq", {31'h0, IO_BotIrq}, {31'h0, e.irq});
                if (e.rd) chk("hrdata", bus.HRDATA, e.rd_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HADDR = 0; bus.HWDATA = 0;
        model_reset();
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        rd(3'd4);                                   // CNT after reset
        wr(3'd0, 32'h0000_00A5); rd(3'd0); idle(0, 0); // CTRL write, back-to-back read
        idle(1, 32'h1234_5678); rd(3'd1); rd(3'd2); rd(3'd4);
        idle(1, 32'hCAFE_0001); rd(3'd2); rd(3'd4);
        wr(3'd3, 32'h1); idle(0, 0); rd(3'd2);
        idle(1, 32'h0BAD_F00D); idle(1, 32'h0000_0042); rd(3'd2);
        wr(3'd3, 32'h1); idle(1, 32'h7777_8888); rd(3'd2); rd(3'd4); // ACK/update collision
        wr(3'd3, 32'hFFFF_FFFE); rd(3'd2);          // ACK bit0=0
        wr(3'd3, 32'h1); rd(3'd2);                  // STAT read right behind ACK
        rd(3'd1); idle(1, 32'hA0A0_B0B0); rd(3'd1); // INFO read coincident with update
        for (int i = 0; i < 16; i++) idle(1, 32'(i));
        rd(3'd4);                                   // wraps back to the same count
        rd(3'd6); wr(3'd6, 32'hFFFF_FFFF); rd(3'd0); rd(3'd2); rd(3'd4); rd(3'd7);
        wr(3'd0, 32'h0000_005A);
        mid_reset();
        rd(3'd4); rd(3'd0);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] a;
            a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
            cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom(),
                ($urandom_range(0, 3) == 0), $urandom());
            if (i == 300) begin
                mid_reset();
                rd(3'd2);
            end
        end
        idle(0, 0);
        repeat (3) @(negedge HCLK);
        chk("scb_drain", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
